fx2_fifo_scheduler: RTL and testbench
=====================================

// Module: fx2_fifo_scheduler
// PURPOSE
//  Sequences the FX2 slave-FIFO bus (usb_data/usb_addr/usb_sl*) for the board top level. Shares the single
//  8-bit bus between host->FPGA reads (EP2 OUT) and FPGA->host writes (EP6 IN) with round-robin
//  burst arbitration. Exposes byte streams (rx_*, tx_*) to fabric logic and handles bus turnaround and PKTEND.
//  clk0 is the FX2 IFCLK domain, so no synchronisers are needed.
// PARAMETERS
//  BURST_MAX      16    max bytes moved in one direction before re-arbitration (1..255)
//  TIMEOUT_CYCLES 4096  idle cycles before auto-PKTEND (only with FX2_PKTEND_TIMEOUT_EN)
// PORTS
//  clk0          in   1  system clock (FX2 IFCLK)
//  reset         in   1  synchronous, active-high reset
//  usb_flagb     in   1  EP2 empty flag, active low (0 = EP2 empty)
//  usb_flagc     in   1  EP6 full flag, active low (0 = EP6 full)
//  usb_data_in   in   8  sampled usb_data
//  usb_data_out  out  8  drive value for usb_data
//  usb_data_oe   out  1  1 = top level drives usb_data from usb_data_out
//  usb_addr      out  2  FIFO select: 2'b00 = EP2, 2'b10 = EP6
//  usb_slcs      out  1  chip select, active low
//  usb_sloe      out  1  output enable, active low
//  usb_slrd      out  1  read strobe, active low
//  usb_slwr      out  1  write strobe, active low
//  usb_pktend    out  1  packet end, active low
//  rx_data       out  8  byte read from EP2
//  rx_valid      out  1  rx_data valid; held until rx_ready
//  rx_ready      in   1  consumer accepts rx_data
//  tx_data       in   8  byte to write to EP6
//  tx_valid      in   1  tx_data valid
//  tx_ready      out  1  one-cycle pulse: tx_data consumed this cycle
//  tx_flush      in   1  pulse: commit partial EP6 packet (PKTEND)
// BEHAVIOUR
//  Reset values: usb_slcs=0, usb_sloe/slrd/slwr/pktend=1, usb_data_oe=0, usb_addr=2'b00, usb_data_out=0,
//   rx_valid=0, rx_data=0, tx_ready=0; state=IDLE, last_grant=WR, burst count=0, flush_pend=0.
//  Reset mid-transfer aborts at once: all strobes deassert on the next edge; no partial byte is delivered.
//  All FX2 outputs are registered. A strobe asserts for exactly one cycle, followed by one gap cycle
//   (CHECK) before flags are re-sampled. Peak rate is 1 byte per 2 cycles.
//  rd_req = usb_flagb & ~rx_valid;  wr_req = usb_flagc & tx_valid;  pk_req = flush_pend & usb_flagc.
//  States: IDLE, RD_SEL, RD_STB, RD_CHK, WR_SEL, WR_STB, WR_CHK, PKTEND, TURN.
//  IDLE: grant priority pk_req > alternate direction of last_grant > same direction; no request -> stay.
//   Grant RD -> RD_SEL; grant WR -> WR_SEL; grant pk -> WR_SEL with pktend pending.
//  RD_SEL: usb_addr=00, usb_sloe=0, usb_data_oe=0 (1 cycle turnaround) -> RD_STB.
//  RD_STB: usb_slrd=0 for 1 cycle; rx_data<=usb_data_in and rx_valid<=1 on the same edge; count++ -> RD_CHK.
//  RD_CHK: slrd=1; if usb_flagb & rx_ready & count<BURST_MAX -> RD_STB, else -> TURN.
//  WR_SEL: usb_addr=10, usb_sloe=1, usb_data_oe=1 -> WR_STB (or PKTEND if only pk_req).
//  WR_STB: usb_data_out=tx_data, usb_slwr=0 for 1 cycle; tx_ready=1 same cycle; count++ -> WR_CHK.
//  WR_CHK: slwr=1; if wr_req & count<BURST_MAX -> WR_STB; elif pk_req -> PKTEND; else -> TURN.
//  PKTEND: usb_pktend=0 for 1 cycle, flush_pend<=0 -> TURN. PKTEND is never issued while EP6 is full.
//  TURN: sloe=1, data_oe=0, count=0, last_grant updated -> IDLE. Direction changes always pass TURN,
//   so FX2 and FPGA never drive usb_data in the same cycle.
//  rx_valid clears on rx_valid&rx_ready. A new read is never strobed while rx_valid=1, so no byte is lost.
//  flush_pend sets on tx_flush. A flush arriving in the same cycle as a byte write applies after that byte.
//  Flag boundary: flags are sampled only in IDLE/*_CHK. EP2 going empty or EP6 going full ends the burst cleanly.
//  count is 8 bits and never wraps: it saturates at BURST_MAX, then the state returns through TURN.
// CONFIGURATION
//  FX2_PKTEND_TIMEOUT_EN defined: a counter tracks cycles since the last EP6 write while a partial packet
//   is outstanding (>=1 byte written since the last PKTEND). At TIMEOUT_CYCLES it sets flush_pend.
//   Any write or PKTEND resets the counter.
//  Not defined: PKTEND is issued only on tx_flush; no counter logic is instantiated.
// TESTING
//  1 reset, then flagb=0 flagc=1 tx_valid=0 for 50 cycles -> all strobes stay 1, state IDLE, data_oe=0.
//  2 flagb=1, EP2 model holds 0x11..0x14 then goes empty, rx_ready=1 -> 4 slrd pulses, 2 cycles apart;
//    rx_data 0x11,0x12,0x13,0x14 in order; EP2 empty ends the burst.
//  3 BURST_MAX=4, EP2 full and tx_valid held with 0xA0.. -> 4 reads, TURN, 4 writes, TURN, then reads again;
//    data_oe=0 for >=1 cycle at each switch.
//  4 write 3 bytes, pulse tx_flush -> 3 slwr pulses then 1 pktend pulse with addr=10.
//    With flagc=0 during the flush, pktend waits until flagc=1.
//  5 rx_ready=0 with EP2 non-empty -> exactly 1 slrd, rx_valid stays 1, no further slrd until rx_ready.
//  6 reset asserted during WR_STB -> next edge: slwr=1, data_oe=0, rx_valid=0.
//    With FX2_PKTEND_TIMEOUT_EN and TIMEOUT_CYCLES=64: 1 byte, then idle -> pktend at 64+-2 cycles.

Source files
------------

// File: rtl/fx2_fifo_scheduler.sv
// FX2 slave-FIFO bus sequencer: EP2 OUT reads and EP6 IN writes, round-robin bursts.
// Optional macro FX2_PKTEND_TIMEOUT_EN adds an idle auto-PKTEND timer.
module fx2_fifo_scheduler #(
    parameter int BURST_MAX      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk0,
    input  logic       reset,
    input  logic       usb_flagb,
    input  logic       usb_flagc,
    input  logic [7:0] usb_data_in,
    output logic [7:0] usb_data_out,
    output logic       usb_data_oe,
    output logic [1:0] usb_addr,
    output logic       usb_slcs,
    output logic       usb_sloe,
    output logic       usb_slrd,
    output logic       usb_slwr,
    output logic       usb_pktend,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_flush
);
    typedef enum logic [3:0] {
        IDLE, RD_SEL, RD_STB, RD_CHK,
        WR_SEL, WR_STB, WR_CHK, PKTEND, TURN
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;
    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    state_t     state;
    logic       last_grant;
    logic       cur_dir;
    logic [7:0] count;
    logic       flush_pend;
    logic       rd_req, wr_req, pk_req;
    logic       grant_rd, grant_wr;
    logic       burst_ok;
    logic       set_pend;

    assign rd_req   = usb_flagb & ~rx_valid;
    assign wr_req   = usb_flagc & tx_valid;
    assign pk_req   = flush_pend & usb_flagc;
    assign burst_ok = count < BMAX;

    // pk first, then the direction not served last, then the same one
    assign grant_wr = pk_req | (wr_req & ((last_grant == DIR_RD) | ~rd_req));
    assign grant_rd = ~grant_wr & rd_req;

`ifdef FX2_PKTEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // expires early so PKTEND lands TIMEOUT_CYCLES after the last write strobe
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 4);

    logic [TW-1:0] tmo_cnt;
    logic          partial;

    always_ff @(posedge clk0) begin
        if (reset) begin
            tmo_cnt <= '0;
            partial <= 1'b0;
        end else if (state == WR_STB) begin
            tmo_cnt <= '0;
            partial <= 1'b1;
        end else if (state == PKTEND) begin
            tmo_cnt <= '0;
            partial <= 1'b0;
        end else if (partial && !flush_pend && tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign set_pend = tx_flush |
                      (partial & ~flush_pend & (tmo_cnt == TMO_LAST));
`else
    assign set_pend = tx_flush;
`endif

    always_ff @(posedge clk0) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= DIR_WR;
            cur_dir      <= DIR_WR;
            count        <= '0;
            flush_pend   <= 1'b0;
            usb_slcs     <= 1'b0;
            usb_sloe     <= 1'b1;
            usb_slrd     <= 1'b1;
            usb_slwr     <= 1'b1;
            usb_pktend   <= 1'b1;
            usb_data_oe  <= 1'b0;
            usb_addr     <= 2'b00;
            usb_data_out <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            tx_ready     <= 1'b0;
        end else begin
            usb_slrd   <= 1'b1;
            usb_slwr   <= 1'b1;
            usb_pktend <= 1'b1;
            tx_ready   <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (set_pend)
                flush_pend <= 1'b1;
            else if (state == PKTEND)
                flush_pend <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state       <= WR_SEL;
                        cur_dir     <= DIR_WR;
                        usb_addr    <= 2'b10;
                        usb_sloe    <= 1'b1;
                        usb_data_oe <= 1'b1;
                    end else if (grant_rd) begin
                        state       <= RD_SEL;
                        cur_dir     <= DIR_RD;
                        usb_addr    <= 2'b00;
                        usb_sloe    <= 1'b0;
                        usb_data_oe <= 1'b0;
                    end
                end
                RD_SEL: begin
                    state    <= RD_STB;
                    usb_slrd <= 1'b0;
                end
                RD_STB: begin
                    rx_data  <= usb_data_in;
                    rx_valid <= 1'b1;
                    if (count != BMAX)
                        count <= count + 8'd1;
                    state <= RD_CHK;
                end
                RD_CHK: begin
                    if (usb_flagb && rx_ready && burst_ok) begin
                        state    <= RD_STB;
                        usb_slrd <= 1'b0;
                    end else begin
                        state       <= TURN;
                        usb_sloe    <= 1'b1;
                        usb_data_oe <= 1'b0;
                    end
                end
                WR_SEL, WR_CHK: begin
                    if (wr_req && (state == WR_SEL || burst_ok)) begin
                        state        <= WR_STB;
                        usb_slwr     <= 1'b0;
                        usb_data_out <= tx_data;
                        tx_ready     <= 1'b1;
                    end else if (pk_req) begin
                        state      <= PKTEND;
                        usb_pktend <= 1'b0;
                    end else begin
                        state       <= TURN;
                        usb_sloe    <= 1'b1;
                        usb_data_oe <= 1'b0;
                    end
                end
                WR_STB: begin
                    if (count != BMAX)
                        count <= count + 8'd1;
                    state <= WR_CHK;
                end
                PKTEND: begin
                    state       <= TURN;
                    usb_sloe    <= 1'b1;
                    usb_data_oe <= 1'b0;
                end
                TURN: begin
                    count      <= '0;
                    last_grant <= cur_dir;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
// Bench for fx2_fifo_scheduler: FX2 FIFO models, strobe/data scoreboard, directed tests.
`timescale 1ns/1ps
module tb_fx2_fifo_scheduler;
    logic       clk0 = 1'b0;
    logic       reset = 1'b1;
    logic       usb_flagb, usb_flagc;
    logic [7:0] usb_data_in, usb_data_out;
    logic       usb_data_oe;
    logic [1:0] usb_addr;
    logic       usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_flush = 1'b0;

    fx2_fifo_scheduler #(.BURST_MAX(4), .TIMEOUT_CYCLES(64)) dut (
        .clk0(clk0), .reset(reset),
        .usb_flagb(usb_flagb), .usb_flagc(usb_flagc),
        .usb_data_in(usb_data_in), .usb_data_out(usb_data_out),
        .usb_data_oe(usb_data_oe), .usb_addr(usb_addr),
        .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
        .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
        .usb_pktend(usb_pktend),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_flush(tx_flush)
    );

    always #5 clk0 = ~clk0;

    logic [7:0] ep2_mem [0:63];
    logic [7:0] tx_mem  [0:63];
    int   ep2_wr = 0, ep2_rd = 0;
    int   tx_wr = 0, tx_rd = 0;
    logic ep6_full = 1'b0;
    logic started = 1'b0;

    assign usb_flagb   = ep2_rd != ep2_wr;
    assign usb_data_in = ep2_mem[ep2_rd[5:0]];
    assign usb_flagc   = ~ep6_full;
    assign tx_valid    = tx_rd != tx_wr;
    assign tx_data     = tx_mem[tx_rd[5:0]];

    always @(posedge clk0) begin
        if (started && !usb_slrd) ep2_rd <= ep2_rd + 1;
        if (started && tx_ready)  tx_rd  <= tx_rd + 1;
    end

    int total = 0, bad = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] wr_exp[$];
    byte        dir_exp[$];
    int rd_stamp[$];
    int cyc = 0, n_rd = 0, n_wr = 0, n_pk = 0, bus_viol = 0;
    int last_wr_cyc = 0, pk_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic log_dir(input byte d);
        if (dir_exp.size() == 0) check("unexpected_strobe", int'(d), 0);
        else check("strobe_dir", int'(d), int'(dir_exp.pop_front()));
    endtask

    initial begin : monitor
        logic prev_oe, prev_sloe;
        prev_oe = 1'b0;
        prev_sloe = 1'b1;
        forever begin
            @(negedge clk0);
            cyc++;
            if (started) begin
                if (usb_data_oe && !usb_sloe) bus_viol++;
                if (prev_sloe && !usb_sloe && prev_oe) bus_viol++;
                if (!prev_oe && usb_data_oe && !prev_sloe) bus_viol++;
                if (!usb_slrd) begin
                    n_rd++;
                    rd_stamp.push_back(cyc);
                    if (usb_addr != 2'b00 || usb_sloe || usb_data_oe) bus_viol++;
                    log_dir("R");
                end
                if (!usb_slwr) begin
                    n_wr++;
                    last_wr_cyc = cyc;
                    if (usb_addr != 2'b10 || !usb_data_oe) bus_viol++;
                    log_dir("W");
                    if (wr_exp.size() == 0) check("unexpected_wr", usb_data_out, 0);
                    else check("wr_data", usb_data_out, wr_exp.pop_front());
                end
                if (!usb_pktend) begin
                    n_pk++;
                    pk_cyc = cyc;
                    if (!usb_flagc) bus_viol++;
                    check("pktend_addr", usb_addr, 2);
                    log_dir("P");
                end
                if (rx_valid && rx_ready) begin
                    if (rx_exp.size() == 0) check("unexpected_rx", rx_data, 0);
                    else check("rx_data", rx_data, rx_exp.pop_front());
                end
            end
            prev_oe = usb_data_oe;
            prev_sloe = usb_sloe;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "timeout");
    end

    task automatic load_rd(input logic [7:0] b);
        ep2_mem[ep2_wr[5:0]] = b;
        ep2_wr++;
        rx_exp.push_back(b);
    endtask

    task automatic load_wr(input logic [7:0] b);
        tx_mem[tx_wr[5:0]] = b;
        tx_wr++;
        wr_exp.push_back(b);
    endtask

    task automatic push_dir(input byte d, input int n);
        for (int i = 0; i < n; i++) dir_exp.push_back(d);
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((dir_exp.size() != 0 || rx_exp.size() != 0 ||
                wr_exp.size() != 0) && n < max) begin
            @(posedge clk0);
            n++;
        end
        check({name, "_drained"}, int'(n < max), 1);
        repeat (6) @(posedge clk0);
        #1;
    endtask

    task automatic pulse_flush();
        @(posedge clk0); #1;
        tx_flush = 1'b1;
        @(posedge clk0); #1;
        tx_flush = 1'b0;
    endtask

    task automatic check_reset_outs();
        check("rst_slcs", usb_slcs, 0);
        check("rst_sloe", usb_sloe, 1);
        check("rst_slrd", usb_slrd, 1);
        check("rst_slwr", usb_slwr, 1);
        check("rst_pktend", usb_pktend, 1);
        check("rst_data_oe", usb_data_oe, 0);
        check("rst_addr", usb_addr, 0);
        check("rst_data_out", usb_data_out, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 0);
    endtask

    initial begin : stim
        int base, pk0, n;
        repeat (3) @(posedge clk0);
        #1;
        started = 1'b1;
        check_reset_outs();

        // 1: idle with EP2 empty and nothing to send
        reset = 1'b0;
        repeat (50) @(posedge clk0);
        #1;
        check("t1_no_rd", n_rd, 0);
        check("t1_no_wr", n_wr, 0);
        check("t1_no_pk", n_pk, 0);
        check("t1_data_oe", usb_data_oe, 0);
        check("t1_sloe", usb_sloe, 1);

        // 2: four bytes then EP2 empty
        for (int i = 0; i < 4; i++) load_rd(8'h11 + 8'(i));
        push_dir("R", 4);
        drain("t2", 60);
        check("t2_rd_count", n_rd, 4);
        for (int i = 1; i < 4; i++)
            check("t2_rd_spacing", rd_stamp[i] - rd_stamp[i-1], 2);
        repeat (20) @(posedge clk0);
        #1;
        check("t2_burst_ended", n_rd, 4);

        // 3: both directions busy, bursts of 4 alternate
        reset = 1'b1;
        repeat (2) @(posedge clk0);
        #1;
        check_reset_outs();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) load_rd(8'h30 + 8'(i));
        for (int i = 0; i < 8; i++) load_wr(8'hA0 + 8'(i));
        push_dir("R", 4); push_dir("W", 4);
        push_dir("R", 4); push_dir("W", 4);
        push_dir("R", 8);
        drain("t3", 300);
        check("t3_rd_count", n_rd, 20);
        check("t3_wr_count", n_wr, 8);

        // 4: three bytes and flush, then flush while EP6 full
        for (int i = 0; i < 3; i++) load_wr(8'hB1 + 8'(i));
        push_dir("W", 3);
        drain("t4_wr", 60);
        pk0 = n_pk;
        push_dir("P", 1);
        pulse_flush();
        drain("t4_pk", 40);
        check("t4_pk_count", n_pk, pk0 + 1);
        ep6_full = 1'b1;
        pulse_flush();
        repeat (20) @(posedge clk0);
        #1;
        check("t4_pk_held_full", n_pk, pk0 + 1);
        push_dir("P", 1);
        ep6_full = 1'b0;
        drain("t4_pk2", 40);
        check("t4_pk_after_full", n_pk, pk0 + 2);

        // 5: consumer stalls
        base = n_rd;
        rx_ready = 1'b0;
        load_rd(8'h55);
        load_rd(8'h66);
        push_dir("R", 1);
        repeat (20) @(posedge clk0);
        #1;
        check("t5_one_rd", n_rd - base, 1);
        check("t5_rx_valid", rx_valid, 1);
        check("t5_rx_held", rx_data, 8'h55);
        push_dir("R", 1);
        rx_ready = 1'b1;
        drain("t5", 60);
        check("t5_two_rd", n_rd - base, 2);

        // 6: reset during a write strobe
        load_wr(8'hC0);
        push_dir("W", 1);
        n = 0;
        do begin
            @(negedge clk0);
            n++;
        end while (usb_slwr && n < 30);
        check("t6_wr_stb_seen", usb_slwr, 0);
        reset = 1'b1;
        @(posedge clk0);
        #1;
        check("t6_slwr", usb_slwr, 1);
        check("t6_data_oe", usb_data_oe, 0);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_tx_ready", tx_ready, 0);
        @(posedge clk0);
        #1;
        reset = 1'b0;
        drain("t6", 20);
        check("t6_no_extra_wr", tx_valid, 0);

`ifdef FX2_PKTEND_TIMEOUT_EN
        load_wr(8'hD0);
        push_dir("W", 1);
        push_dir("P", 1);
        drain("t7", 200);
        check("t7_timeout_window",
              int'((pk_cyc - last_wr_cyc) >= 62 && (pk_cyc - last_wr_cyc) <= 66), 1);
`endif

        check("bus_protocol", bus_viol, 0);
        check("dir_queue_empty", dir_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
